// File: rtl/tdm_pkg.sv
// Shared constants and lane entry type for the TDM ingress path into the
// 10-port switch core.
package tdm_pkg;

   localparam int unsigned NUM_PORTS  = 10;
   localparam int unsigned FRAME_LEN  = 256;
   localparam int unsigned SLOT_W     = 8;
   localparam int unsigned DATA_WIDTH = 8;

   typedef struct packed {
      logic                  sop;
      logic [DATA_WIDTH-1:0] data;
   } tdm_entry_t;

   localparam tdm_entry_t IDLE_ENTRY = '{sop: 1'b0, data: '0};

endpackage

// File: rtl/tdm_port_fifo.sv
// Per-port synchronous FIFO: register storage, wrapping pointers, level count.
module tdm_port_fifo
   import tdm_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  tdm_entry_t       push_entry,
   input  logic             pop,
   output tdm_entry_t       head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   tdm_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while the level says valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/tdm_ingress_mux.sv
// Slot-driven multiplexer: buffers ten port streams and emits port k's head
// byte only in slot k of a free-running 256-cycle frame.
module tdm_ingress_mux
   import tdm_pkg::tdm_entry_t, tdm_pkg::IDLE_ENTRY, tdm_pkg::SLOT_W, tdm_pkg::FRAME_LEN;
#(
   parameter int unsigned DATA_WIDTH = tdm_pkg::DATA_WIDTH,
   parameter int unsigned NUM_PORTS  = tdm_pkg::NUM_PORTS,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [NUM_PORTS-1:0]                         in_valid,
   input  logic [NUM_PORTS-1:0]                         in_sop,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]              in_data,
   output logic [NUM_PORTS-1:0]                         in_ready,
   output logic                                         output_wire,
   output logic                                         output_new_packet,
   output logic [DATA_WIDTH-1:0]                        output_data,
   output logic [7:0]                                   slot_o,
   output logic [NUM_PORTS*($clog2(FIFO_DEPTH)+1)-1:0]  fifo_level
);

   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [SLOT_W-1:0]    slot;
   logic [SLOT_W-1:0]    next_slot;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] full;
   tdm_entry_t           head [NUM_PORTS];
   tdm_entry_t           lane_d;
   tdm_entry_t           lane_q;
   logic                 lane_valid_d;
   logic                 lane_valid_q;

   assign next_slot = (slot == SLOT_W'(FRAME_LEN - 1)) ? '0 : slot + SLOT_W'(1);

   for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
      tdm_port_fifo #(
         .DEPTH (FIFO_DEPTH),
         .LVL_W (LVL_W)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .push       (in_valid[k]),
         .push_entry ('{sop: in_sop[k], data: in_data[k*DATA_WIDTH +: DATA_WIDTH]}),
         .pop        (pop[k]),
         .head       (head[k]),
         .full       (full[k]),
         .empty      (empty[k]),
         .level      (fifo_level[k*LVL_W +: LVL_W])
      );
   end

   assign in_ready = ~full;

   // Decode on the slot being entered so the registered lane lines up with slot_o.
   always_comb begin
      pop          = '0;
      lane_valid_d = 1'b0;
      lane_d       = IDLE_ENTRY;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
         if (next_slot == SLOT_W'(k) && !empty[k]) begin
            pop[k]       = 1'b1;
            lane_valid_d = 1'b1;
            lane_d       = head[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot         <= '0;
         lane_valid_q <= 1'b0;
         lane_q       <= IDLE_ENTRY;
      end else begin
         slot         <= next_slot;
         lane_valid_q <= lane_valid_d;
         lane_q       <= lane_d;
      end
   end

   assign output_wire       = lane_valid_q;
   assign output_new_packet = lane_q.sop;
   assign output_data       = lane_q.data;
   assign slot_o            = slot;

endmodule

// File: doc/tdm_ingress_mux.md
# tdm_ingress_mux

Time-division multiplexer that drives the shared 8-bit ingress lane (valid, new-packet, data) of the 10-port switch core. It accepts ten independent per-port byte streams, buffers each in a small FIFO, and emits port k's next byte only in slot k of a free-running 256-cycle frame. Its slot counter resets and counts exactly like the core's input slot counter, so slot k on this lane lands on switch input k.

## Interface
- `DATA_WIDTH`, 8: byte lane width.
- `NUM_PORTS`, 10: number of ingress ports; must be ≤ 256.
- `FIFO_DEPTH`, 16: entries per port FIFO; power of two, ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  NUM_PORTS  per-port byte offered.
- `in_sop`  in  NUM_PORTS  per-port byte is first of a packet.
- `in_data`  in  NUM_PORTS*DATA_WIDTH  per-port byte; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_ready`  out  NUM_PORTS  per-port FIFO not full.
- `output_wire`  out  1  lane valid, to switch `input_wire`.
- `output_new_packet`  out  1  lane SOP, to switch `input_new_packet`.
- `output_data`  out  DATA_WIDTH  lane byte, to switch `input_data`.
- `slot_o`  out  8  current slot number; equals the switch's slot counter.
- `fifo_level`  out  NUM_PORTS*($clog2(FIFO_DEPTH)+1)  per-port occupancy, for debug and verification.

## Operation
- Slot counter `slot`, 8-bit, resets to 0 and increments every cycle, wrapping 255→0.
- Slots 0..NUM_PORTS-1 are port slots. Slots NUM_PORTS..255 are idle and drive valid=0, sop=0, data=0.
- Per-port FIFO entry is {sop, data}, 9 bits at default width.
- Push rule:
  - A push occurs when `in_valid[k]` and `in_ready[k]` are both 1.
  - `in_ready[k]` = (level_k < FIFO_DEPTH), evaluated on the current registered level.
  - `in_valid` with `in_ready`=0 is ignored; the source holds the byte.
- Pop rule:
  - At each edge, let n = slot+1 (mod 256), the slot value after the edge.
  - If n < NUM_PORTS and FIFO n is non-empty, pop the head and register output_wire=1, output_new_packet=head.sop, output_data=head.data.
  - Otherwise register all three outputs as 0.
- Lane outputs are therefore always registered and aligned with `slot_o`: the byte shown while slot_o==k belongs to port k.
- Each port drains at most one byte per 256-cycle frame.
- Simultaneous push and pop on the same port: both take effect; level is unchanged.
- Push into an empty FIFO: the byte becomes poppable on the following edge, not the same edge.
- SOP is carried through unmodified. The block does no packet-boundary checks.

## Timing
- Reset values: slot=0; all FIFOs empty with levels 0; output_wire=0; output_new_packet=0; output_data=0; in_ready all 1.
- Slot 0 of the first frame after reset is always idle, because the outputs are still at reset values.
- Latency from push to lane:
  - Earliest: the byte appears while slot_o==k, provided the push edge is at least one cycle before the edge entering slot k.
  - Worst case: 257 cycles.
- Full boundary: when level=FIFO_DEPTH, `in_ready` is 0. If a pop occurs that cycle, `in_ready` returns to 1 the next cycle.
- Empty boundary: a port slot with an empty FIFO emits an idle byte. The block does not borrow bytes from other ports.
- Reset asserted mid-operation:
  - All registers clear immediately (asynchronous reset).
  - FIFO contents are discarded.
  - The lane goes idle in the same cycle.
  - The slot counter restarts at 0 in lockstep with the switch, which shares `rst`.

## Structure
- Shared package `tdm_pkg`:
  - NUM_PORTS.
  - FRAME_LEN=256.
  - SLOT_W=8.
  - The FIFO entry typedef {logic sop; logic [DATA_WIDTH-1:0] data;}.
  - The idle-entry constant.
- One sub-module, `tdm_port_fifo`:
  - Synchronous FIFO with push/pop, full/empty and level outputs.
  - Register-based storage with wrap-around read/write pointers.
  - Instantiated NUM_PORTS times from a generate loop.
- Top level contains only:
  - The slot counter.
  - The next-slot decoder producing per-port pop strobes.
  - The output mux and its registers.

## Test plan
- Reset: hold rst=0 for 5 cycles, then release → output_wire=0, output_data=0, slot_o=0,1,2… with no X; in_ready=10'h3FF.
- Single byte: push 8'hA5 with sop=1 on port 3 while slot_o=0 → in the cycle with slot_o==3, output_wire=1, output_new_packet=1, output_data=8'hA5; every other slot is idle.
- Multi-byte packet: push 4 bytes {11,22,33,44} to port 0, sop on the first only → they appear at slot_o==0 of four consecutive frames, 256 cycles apart; new_packet is 1 only on 8'h11.
- Backpressure: push 16 bytes to port 9 within one frame → in_ready[9]=0 after the 16th push; the 17th offered byte is not accepted; after the slot-9 pop, in_ready[9]=1 on the next cycle and fifo_level drops to 15.
- All ports: push one distinct byte (8'h10+k) to each port k at the same time → slots 0..9 of the next frame emit 8'h10..8'h19 in order; slots 10..255 are idle.
- Reset mid-frame: with 5 bytes queued on port 2, assert rst at slot 1 → the lane is idle immediately; after release, fifo_level for port 2 is 0 and no stale byte ever appears at slot 2.
